// File: rtl/flits_tx_buffer.sv
// Transmit side of the NIC flit link: captures a whole packet on request/grant and
// serialises it one flit per cycle under credit-based flow control.
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 5
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 64
`endif

module flits_tx_buffer #(
  parameter int N_BITS_POINTER = $clog2(`MAX_PACKET_LENGHT),
  parameter int N_CREDITS      = `MAX_PACKET_LENGHT,
  parameter int N_BITS_CREDIT  = $clog2(N_CREDITS + 1)
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]   in_link_i,
  input  logic [`MAX_PACKET_LENGHT-1:0]               in_sel_i,
  input  logic                                        r_msg_to_pkt_i,
  output logic                                        g_msg_to_pkt_o,
  output logic [`FLIT_WIDTH-1:0]                      out_link_o,
  output logic                                        is_valid_o,
  input  logic                                        credit_signal_i,
  input  logic                                        free_signal_i,
  output logic                                        busy_o
);

  localparam int MPL = `MAX_PACKET_LENGHT;
  localparam int FW  = `FLIT_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                    state_q, state_d;
  logic [N_BITS_POINTER-1:0] idx_q, idx_d;
  logic [N_BITS_POINTER-1:0] last_q, last_d;
  logic [N_BITS_CREDIT-1:0]  credits_q, credits_d;
  logic [MPL*FW-1:0]         pkt_q, pkt_d;
  logic [FW-1:0]             out_link_q, out_link_d;
  logic                      is_valid_q, is_valid_d;
  logic                      fire;
  logic [FW-1:0]             cur_flit;

  // Index of the highest present flit; holes below it are still transmitted.
  function automatic logic [N_BITS_POINTER-1:0] top_index(input logic [MPL-1:0] sel);
    top_index = '0;
    for (int k = 0; k < MPL; k++)
      if (sel[k]) top_index = N_BITS_POINTER'(k);
  endfunction

  function automatic logic [1:0] flit_type(input logic [N_BITS_POINTER-1:0] idx,
                                           input logic [N_BITS_POINTER-1:0] last);
    if (last == '0)       flit_type = 2'b11;
    else if (idx == '0)   flit_type = 2'b00;
    else if (idx == last) flit_type = 2'b10;
    else                  flit_type = 2'b01;
  endfunction

  assign cur_flit = pkt_q[int'(idx_q)*FW +: FW];

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    last_d         = last_q;
    credits_d      = credits_q;
    pkt_d          = pkt_q;
    out_link_d     = out_link_q;
    is_valid_d     = 1'b0;
    g_msg_to_pkt_o = 1'b0;
    fire           = 1'b0;
    case (state_q)
      IDLE: begin
        g_msg_to_pkt_o = r_msg_to_pkt_i;
        if (r_msg_to_pkt_i && (in_sel_i != '0)) begin
          pkt_d   = in_link_i;
          last_d  = top_index(in_sel_i);
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        // A head flit also waits for the receiver to be free for a new packet.
        fire = (credits_q != '0) && ((idx_q != '0) || free_signal_i);
        if (fire) begin
          out_link_d = {cur_flit[FW-1:2], flit_type(idx_q, last_q)};
          is_valid_d = 1'b1;
          idx_d      = idx_q + N_BITS_POINTER'(1);
          if (idx_q == last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fire && !credit_signal_i)
      credits_d = credits_q - N_BITS_CREDIT'(1);
    else if (!fire && credit_signal_i && (credits_q != N_BITS_CREDIT'(N_CREDITS)))
      credits_d = credits_q + N_BITS_CREDIT'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      last_q     <= '0;
      credits_q  <= N_BITS_CREDIT'(N_CREDITS);
      out_link_q <= '0;
      is_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      credits_q  <= credits_d;
      out_link_q <= out_link_d;
      is_valid_q <= is_valid_d;
    end
  end

  // Packet payload storage is only meaningful while in SEND, so it needs no reset.
  always_ff @(posedge clk) begin
    pkt_q <= pkt_d;
  end

  assign out_link_o = out_link_q;
  assign is_valid_o = is_valid_q;
  assign busy_o     = (state_q == SEND);

endmodule
